// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the RV64 datapath: decodes the returned opcode
// and walks each instruction through DECODE/EXEC/MEM/WB, driving datapath strobes.
module multicycle_ctrl #(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                halt_req,
    input  logic [6:0]          opcode,
    output logic                alusrc,
    output logic                mem2reg,
    output logic                regwrite,
    output logic                memread,
    output logic                memwrite,
    output logic                branch,
    output logic                writepc,
    output logic                startpc,
    output logic [1:0]          aluop,
    output logic                halted,
    output logic                illegal,
    output logic                retire,
    output logic [RETIRE_W-1:0] retired_cnt,
    output logic [2:0]          state_dbg
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        C_NONE   = 3'd0,
        C_R      = 3'd1,
        C_IALU   = 3'd2,
        C_LOAD   = 3'd3,
        C_STORE  = 3'd4,
        C_BRANCH = 3'd5,
        C_SYS    = 3'd6,
        C_ILL    = 3'd7
    } class_e;

    state_e                state_q, state_d;
    class_e                cls_q, cls_d;
    class_e                dec_cls;
    logic                  illegal_q, illegal_d;
    logic [RETIRE_W-1:0]   cnt_q, cnt_d;

    // Opcode classification; only consumed while in DECODE
    always_comb begin
        unique case (opcode)
            OP_R:      dec_cls = C_R;
            OP_IALU:   dec_cls = C_IALU;
            OP_LOAD:   dec_cls = C_LOAD;
            OP_STORE:  dec_cls = C_STORE;
            OP_BRANCH: dec_cls = C_BRANCH;
            OP_SYS:    dec_cls = C_SYS;
            default:   dec_cls = C_ILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cls_q     <= C_NONE;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next state and strobes; strobes see only state_q and the latched class
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        illegal_d = illegal_q;
        alusrc    = 1'b0;
        mem2reg   = 1'b0;
        regwrite  = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        branch    = 1'b0;
        writepc   = 1'b0;
        startpc   = 1'b0;
        aluop     = 2'b00;
        halted    = 1'b0;

        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            alusrc = (cls_q == C_IALU) || (cls_q == C_LOAD) || (cls_q == C_STORE);
            if (cls_q == C_BRANCH)
                aluop = 2'b01;
            else if (cls_q == C_R || cls_q == C_IALU)
                aluop = 2'b10;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = S_INIT;
            end
            S_INIT: begin
                startpc = 1'b1;
                writepc = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                cls_d = dec_cls;
                if (dec_cls == C_ILL)
                    illegal_d = 1'b1;
                if (halt_req || dec_cls == C_ILL || dec_cls == C_SYS)
                    state_d = S_HALTED;
                else
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                if (cls_q == C_BRANCH) begin
                    branch  = 1'b1;
                    writepc = 1'b1;
                    state_d = S_DECODE;
                end else if (cls_q == C_LOAD || cls_q == C_STORE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (cls_q == C_LOAD) begin
                    memread = 1'b1;
                    state_d = S_WB;
                end else begin
                    memwrite = (cls_q == C_STORE);
                    writepc  = (cls_q == C_STORE);
                    state_d  = S_DECODE;
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                writepc  = 1'b1;
                if (cls_q == C_LOAD) begin
                    mem2reg = 1'b1;
                    memread = 1'b1;
                end
                state_d = S_DECODE;
            end
            S_HALTED: begin
                halted = 1'b1;
                if (start) begin
                    state_d   = S_DECODE;
                    illegal_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Retire is the final writepc cycle of an instruction (INIT's PC load excluded)
    always_comb begin
        retire = writepc && (state_q != S_INIT);
        cnt_d  = retire ? cnt_q + RETIRE_W'(1) : cnt_q;
    end

    assign illegal     = illegal_q;
    assign retired_cnt = cnt_q;
    assign state_dbg   = 3'(state_q);

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the 64-bit RISC-V datapath. It decodes the 7-bit `opcode` that the datapath returns, and steps each instruction through DECODE, EXEC, MEM and WB states. In each state it drives the datapath control strobes (`alusrc`, `mem2reg`, `regwrite`, `memread`, `memwrite`, `branch`, `writepc`, `startpc`, `aluop`). It also provides run/halt control and a retired-instruction counter for the bench and the top level.

## Interface

Parameters:
- `RETIRE_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request. Sampled in IDLE and HALTED only.
- `halt_req`  in  1  stop request. Sampled in DECODE only.
- `opcode`  in  7  `instruction[6:0]` from the datapath.
- `alusrc`, `mem2reg`, `regwrite`, `memread`, `memwrite`, `branch`, `writepc`, `startpc`  out  1 each  datapath strobes.
- `aluop`  out  2  ALU control class.
- `halted`  out  1  high in HALTED.
- `illegal`  out  1  sticky flag: an unknown opcode was decoded.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `retired_cnt`  out  `RETIRE_W`  count of retired instructions.
- `state_dbg`  out  3  current state encoding.

## Operation

States and encodings:
- IDLE=0, INIT=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALTED=6.

Opcode classes, decoded in DECODE and latched into a class register:
- R: 0110011
- I-ALU: 0010011
- LOAD: 0000011
- STORE: 0100011
- BRANCH: 1100011
- SYS: 1110011
- Anything else is ILLEGAL.

The latched class drives all later states. Strobes depend only on the current state and the latched class; they never depend on the live `opcode`.

Class-constant strobes, held for every state of the instruction from EXEC onward (0 in IDLE, INIT, DECODE and HALTED):
- `aluop`: LOAD/STORE=00, BRANCH=01, R/I-ALU=10.
- `alusrc`: 1 for I-ALU, LOAD and STORE; 0 otherwise.

State transitions:
- IDLE: all strobes 0. `start` → INIT.
- INIT: `startpc`=1, `writepc`=1 (PC loads 0). Next state DECODE unconditionally.
- DECODE: latch the class. Next state by priority:
  - `halt_req` → HALTED. Nothing is executed or retired.
  - ILLEGAL → HALTED and set `illegal`.
  - SYS → HALTED. Does not retire; PC is not advanced.
  - Otherwise → EXEC.
- EXEC:
  - BRANCH: `branch`=1, `writepc`=1. Retires; next state DECODE.
  - R / I-ALU / LOAD: next state WB for R and I-ALU, MEM for LOAD.
  - STORE: next state MEM.
  - The ALU output register captures the result at the end of EXEC.
- MEM:
  - LOAD: `memread`=1; next state WB.
  - STORE: `memwrite`=1, `writepc`=1. Retires; next state DECODE.
- WB: `regwrite`=1, `writepc`=1.
  - `mem2reg`=1 and `memread`=1 for LOAD; `mem2reg`=0 for R and I-ALU.
  - Retires; next state DECODE.
- HALTED: all strobes 0, `halted`=1.
  - `start` → DECODE: resumes at the current PC, without INIT.
  - `illegal` clears on that transition.

Retire and counter:
- `retire` pulses in the final cycle of each instruction (the cycle where `writepc`=1, excluding INIT).
- `retired_cnt` increments on that edge and wraps modulo 2^`RETIRE_W`.

## Timing

Reset values (asynchronous; apply immediately, independent of `clk`):
- State = IDLE, `state_dbg`=0.
- All strobes 0, `aluop`=00.
- `halted`=0, `illegal`=0, `retire`=0, `retired_cnt`=0.
- Class register cleared.

Cycles per instruction, counted DECODE through the retire cycle:
- BRANCH: 2
- R / I-ALU / STORE: 3
- LOAD: 4

Latency:
- `start` in IDLE: first DECODE occurs 2 cycles later.
- `start` in HALTED: DECODE occurs on the next cycle.

Strobe and request rules:
- Strobes are combinational from registered state and class, and are glitch-free with respect to `opcode` changes mid-instruction.
- Every `regwrite`/`memwrite` assertion lasts exactly 1 cycle.
- `start` asserted outside IDLE/HALTED is ignored.
- `halt_req` asserted outside DECODE has no effect until the next DECODE. An in-flight instruction always completes.
- `halt_req` and ILLEGAL together: HALTED is entered and `illegal` is still set.
- `reset` mid-instruction: return to IDLE immediately. No partial `regwrite`/`memwrite` may occur after reset asserts.

## Test plan

- Reset → `start` at cycle 2: `startpc`=`writepc`=1 in INIT at cycle 3; DECODE at cycle 4; `retired_cnt`=0.
- R-type `add` (0110011) sequence: `state_dbg` 2→3→5; `regwrite`=1 for exactly one cycle with `aluop`=10 and `alusrc`=0; `retire` pulses; `retired_cnt`=1.
- LOAD then STORE: LOAD gives states 2,3,4,5 with `memread` in 4 and 5 and `mem2reg`=1 in 5. STORE gives 2,3,4 with `memwrite`=1 only in 4 and `alusrc`=1 throughout; `retired_cnt`=2.
- BRANCH (1100011): `branch`=`writepc`=1 in EXEC with `aluop`=01; next state is DECODE after 2 cycles.
- Opcode 7'h7F in DECODE → HALTED with `illegal`=1 and no `writepc`. Then `start` → DECODE with `illegal`=0. `halt_req` held during a LOAD's EXEC → the LOAD completes, then HALTED.
- `RETIRE_W`=4 with 17 R-type retires → `retired_cnt`=1. `reset` asserted in MEM of a STORE → `memwrite` drops combinationally and state becomes IDLE.
